relay_bbm_sequencer: RTL

//  Break-before-make sequencer between the relay-state decoder and the CH1..CH20 / Bus2 opto-relay pins.

---
 rtl/relay_bbm_sequencer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/relay_bbm_sequencer.sv
// Break-before-make sequencer: releases switched-off relays first, waits a dead time,
// then drives newly enabled relays, and signals completion after a settle interval.
module relay_bbm_sequencer #(
  parameter int NCH           = 22,
  parameter int BREAK_CYCLES  = 1200,
  parameter int SETTLE_CYCLES = 6000
) (
  input  logic           CLK_SYS,
  input  logic           RESET,
  input  logic [NCH-1:0] STATE_IN,
  input  logic           STATE_VALID,
  output logic [NCH-1:0] RELAY_OUT,
  output logic           BUSY,
  output logic           DONE,
  output logic           OVERRUN
);

  localparam int MAXC = (BREAK_CYCLES > SETTLE_CYCLES) ? BREAK_CYCLES : SETTLE_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] BRK_LD = CW'(BREAK_CYCLES - 1);
  localparam logic [CW-1:0] SET_LD = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    BREAK_WAIT = 2'd1,
    SETTLE     = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [NCH-1:0] relay_q, relay_d;
  logic [NCH-1:0] tgt_q, tgt_d;
  logic [NCH-1:0] pend_q, pend_d;
  logic           pendFlag_q, pendFlag_d;
  logic           done_q, done_d;
  logic           overrun_q, overrun_d;
  logic [NCH-1:0] req, offMask, onMask;

  always_ff @(posedge CLK_SYS) begin
    if (RESET) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      relay_q    <= '0;
      tgt_q      <= '0;
      pend_q     <= '0;
      pendFlag_q <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      relay_q    <= relay_d;
      tgt_q      <= tgt_d;
      pend_q     <= pend_d;
      pendFlag_q <= pendFlag_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    relay_d    = relay_q;
    tgt_d      = tgt_q;
    pend_d     = pend_q;
    pendFlag_d = pendFlag_q;
    done_d     = 1'b0;
    overrun_d  = 1'b0;
    req        = STATE_VALID ? STATE_IN : pend_q;
    offMask    = relay_q & ~req;
    onMask     = req & ~relay_q;

    case (state_q)
      IDLE: begin
        // A fresh strobe takes priority and silently drops any pending word.
        if (STATE_VALID || pendFlag_q) begin
          pendFlag_d = 1'b0;
          if (offMask == '0 && onMask == '0) begin
            done_d = 1'b1;
          end else if (offMask != '0 && onMask != '0) begin
            relay_d = relay_q & req;
            tgt_d   = req;
            cnt_d   = BRK_LD;
            state_d = BREAK_WAIT;
          end else begin
            relay_d = req;
            cnt_d   = SET_LD;
            state_d = SETTLE;
          end
        end
      end
      BREAK_WAIT: begin
        if (cnt_q == '0) begin
          relay_d = tgt_q;
          cnt_d   = SET_LD;
          state_d = SETTLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // While a sequence runs, requests queue one deep and the latest wins.
    if (state_q != IDLE && STATE_VALID) begin
      pend_d     = STATE_IN;
      pendFlag_d = 1'b1;
      overrun_d  = pendFlag_q;
    end
  end

  assign RELAY_OUT = relay_q;
  assign DONE      = done_q;
  assign OVERRUN   = overrun_q;
  assign BUSY      = (state_q != IDLE) | pendFlag_q;

endmodule
